// File: rtl/delta_encoder.sv
// Stream difference encoder: Diff = Data - previous sample, with an output FIFO for backpressure.
// Optional saturating mode with per-entry Ovf flag when DELTA_ENC_SAT_EN is defined.
module delta_encoder #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] Data,
    input  logic             Start,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Diff,
    output logic             OutFirst
`ifdef DELTA_ENC_SAT_EN
    ,
    output logic             Ovf
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, RUN} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] ref_q, ref_d;
    logic [CW-1:0]    count_q, count_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] diff_mem_q [DEPTH];
    logic [WIDTH-1:0] diff_mem_d [DEPTH];
    logic             first_mem_q [DEPTH];
    logic             first_mem_d [DEPTH];

    logic             push, pop;
    logic [WIDTH-1:0] enc_diff;
    logic             enc_first;

`ifdef DELTA_ENC_SAT_EN
    localparam logic signed [WIDTH:0] D_MAX = {2'b00, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH:0] D_MIN = {2'b11, {(WIDTH-1){1'b0}}};

    logic             ovf_mem_q [DEPTH];
    logic             ovf_mem_d [DEPTH];
    logic             enc_ovf;
    logic signed [WIDTH:0] d_full;
    logic signed [WIDTH:0] d_clamp;
`endif

    assign InReady  = (count_q != CW'(DEPTH));
    assign OutValid = (count_q != '0);
    assign Diff     = diff_mem_q[rd_ptr_q];
    assign OutFirst = first_mem_q[rd_ptr_q];
`ifdef DELTA_ENC_SAT_EN
    assign Ovf      = ovf_mem_q[rd_ptr_q];
`endif

    assign push = InValid && InReady;
    assign pop  = OutValid && OutReady;

    always_comb begin
        enc_first = (state_q == IDLE) || Start;
        enc_diff  = Data;
        ref_d     = ref_q;
        state_d   = state_q;
`ifdef DELTA_ENC_SAT_EN
        enc_ovf = 1'b0;
        d_full  = $signed({1'b0, Data}) - $signed({1'b0, ref_q});
        d_clamp = d_full;
`endif
        if (push) begin
            state_d = RUN;
            if (enc_first) begin
                enc_diff = Data;
                ref_d    = Data;
            end else begin
`ifdef DELTA_ENC_SAT_EN
                if (d_full > D_MAX) begin
                    d_clamp = D_MAX;
                    enc_ovf = 1'b1;
                end else if (d_full < D_MIN) begin
                    d_clamp = D_MIN;
                    enc_ovf = 1'b1;
                end
                enc_diff = d_clamp[WIDTH-1:0];
                // Closed loop: ref follows what the downstream accumulator will hold.
                ref_d    = ref_q + d_clamp[WIDTH-1:0];
`else
                enc_diff = Data - ref_q;
                ref_d    = Data;
`endif
            end
        end
    end

    always_comb begin
        diff_mem_d  = diff_mem_q;
        first_mem_d = first_mem_q;
`ifdef DELTA_ENC_SAT_EN
        ovf_mem_d   = ovf_mem_q;
`endif
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (push) begin
            diff_mem_d[wr_ptr_q]  = enc_diff;
            first_mem_d[wr_ptr_q] = enc_first;
`ifdef DELTA_ENC_SAT_EN
            ovf_mem_d[wr_ptr_q]   = enc_ovf;
`endif
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            ref_q    <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                diff_mem_q[i]  <= '0;
                first_mem_q[i] <= 1'b0;
`ifdef DELTA_ENC_SAT_EN
                ovf_mem_q[i]   <= 1'b0;
`endif
            end
        end else begin
            state_q     <= state_d;
            ref_q       <= ref_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            diff_mem_q  <= diff_mem_d;
            first_mem_q <= first_mem_d;
`ifdef DELTA_ENC_SAT_EN
            ovf_mem_q   <= ovf_mem_d;
`endif
        end
    end

endmodule
